bank_read_sequencer: RTL and testbench

Burst read sequencer that sits directly upstream of the 16 x 4-bit memory bank. It accepts a burst request (start address, word count), drives the bank's chip-enable and address, and registers each returned word. It then presents the words as a valid/ready stream with a last flag and a running 8-bit sum, so downstream logic reads the bank one word per cycle without handling its addressing or tri-state output.

---
 rtl/bank_read_sequencer_if.sv | 30 +++
 rtl/bank_read_sequencer.sv | 116 +++++++++++
 tb/tb_bank_read_sequencer.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bank_read_sequencer_if.sv
// Request, bank and output-stream signals of the burst read sequencer.
// master = sequencer side, slave = the bank/requester/consumer side.
interface bank_read_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_addr;
  logic [3:0] req_count;
  logic       mem_ce;
  logic [3:0] mem_addr;
  logic [3:0] mem_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [3:0] out_addr;
  logic       out_last;
  logic [7:0] sum;
  logic       done;

  modport master (
    input  req_valid, req_addr, req_count, mem_data, out_ready,
    output req_ready, mem_ce, mem_addr, out_valid, out_data, out_addr,
           out_last, sum, done
  );

  modport slave (
    output req_valid, req_addr, req_count, mem_data, out_ready,
    input  req_ready, mem_ce, mem_addr, out_valid, out_data, out_addr,
           out_last, sum, done
  );
endinterface

// File: rtl/bank_read_sequencer.sv
// Burst reader for a 16 x 4-bit bank: prefetches one word ahead so the output
// stream sustains one word per cycle, with last flag, running sum and done pulse.
module bank_read_sequencer (
  input logic                   clk,
  input logic                   rst,
  bank_read_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] cur_addr;
  logic [3:0] remaining;
  logic [3:0] data_q;
  logic [3:0] addr_q;
  logic [7:0] sum_q;
  logic       beat;
  logic       last_beat;

  assign last_beat = (remaining == 4'd0);
  assign beat      = (state == STREAM) && bus.out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: the next-state default is assigned first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.req_valid) state_next = FETCH;
      FETCH:   state_next = STREAM;
      STREAM:  if (beat && last_beat) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bank address is forced to 0 whenever the chip-enable is low.
  always_comb begin
    bus.req_ready = 1'b0;
    bus.mem_ce    = 1'b0;
    bus.mem_addr  = 4'd0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    bus.done      = 1'b0;
    case (state)
      IDLE: bus.req_ready = !rst;
      FETCH: begin
        bus.mem_ce   = 1'b1;
        bus.mem_addr = cur_addr;
      end
      STREAM: begin
        bus.out_valid = 1'b1;
        bus.out_last  = last_beat;
        if (!last_beat) begin
          bus.mem_ce   = 1'b1;
          bus.mem_addr = cur_addr;
        end
      end
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  // NOTE: the data registers drive outputs directly, so they are reset too;
  // leaving them unreset would expose X on out_data/out_addr after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr  <= 4'd0;
      remaining <= 4'd0;
      data_q    <= 4'd0;
      addr_q    <= 4'd0;
      sum_q     <= 8'd0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          cur_addr  <= bus.req_addr;
          remaining <= bus.req_count;
          sum_q     <= 8'd0;
        end
        FETCH: begin
          data_q   <= bus.mem_data;
          addr_q   <= cur_addr;
          cur_addr <= cur_addr + 4'd1;
        end
        STREAM: if (beat) begin
          sum_q <= sum_q + {4'd0, data_q};
          // Load the prefetched word; cur_addr wraps 15 -> 0 naturally.
          if (!last_beat) begin
            data_q    <= bus.mem_data;
            addr_q    <= cur_addr;
            cur_addr  <= cur_addr + 4'd1;
            remaining <= remaining - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_data = data_q;
  assign bus.out_addr = addr_q;
  assign bus.sum      = sum_q;

endmodule

// File: tb/tb_bank_read_sequencer.sv
// Directed bench for bank_read_sequencer: a burst-level reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_bank_read_sequencer;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  bank_read_sequencer_if bus ();

  bank_read_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [3:0] mem [16];
  assign bus.mem_data = bus.mem_ce ? mem[bus.mem_addr] : 4'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int word_at(input int a);
    return int'(mem[a % 16]);
  endfunction

  // Reference model: a burst is (base, count); beat k carries address base+k.
  bit m_started = 0;
  bit m_fetch   = 0;
  bit m_stream  = 0;
  bit m_done    = 0;
  int m_base    = 0;
  int m_count   = 0;
  int m_k       = 0;
  int m_sum     = 0;

  always @(posedge clk) begin
    m_started <= 1'b1;
    if (rst) begin
      m_fetch  <= 1'b0;
      m_stream <= 1'b0;
      m_done   <= 1'b0;
      m_sum    <= 0;
      m_k      <= 0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_fetch) begin
      m_fetch  <= 1'b0;
      m_stream <= 1'b1;
      m_k      <= 0;
    end else if (m_stream) begin
      if (bus.out_ready) begin
        m_sum <= m_sum + word_at(m_base + m_k);
        if (m_k == m_count) begin
          m_stream <= 1'b0;
          m_done   <= 1'b1;
        end else begin
          m_k <= m_k + 1;
        end
      end
    end else if (bus.req_valid) begin
      m_base  <= int'(bus.req_addr);
      m_count <= int'(bus.req_count);
      m_sum   <= 0;
      m_fetch <= 1'b1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_started) begin
      logic       exp_ce;
      logic [3:0] exp_maddr;
      exp_ce    = m_fetch || (m_stream && m_k < m_count);
      exp_maddr = m_fetch ? 4'(m_base % 16) : (exp_ce ? 4'((m_base + m_k + 1) % 16) : 4'd0);
      check("req_ready", 32'(bus.req_ready), 32'(!m_fetch && !m_stream && !m_done && !rst));
      check("mem_ce", 32'(bus.mem_ce), 32'(exp_ce));
      check("mem_addr", 32'(bus.mem_addr), 32'(exp_maddr));
      check("out_valid", 32'(bus.out_valid), 32'(m_stream));
      check("out_last", 32'(bus.out_last), 32'(m_stream && m_k == m_count));
      check("done", 32'(bus.done), 32'(m_done));
      check("sum", 32'(bus.sum), 32'(m_sum));
      if (m_stream) begin
        check("out_data", 32'(bus.out_data), 32'(word_at(m_base + m_k)));
        check("out_addr", 32'(bus.out_addr), 32'((m_base + m_k) % 16));
      end
    end
  end

  // Record transferred beats and bank addresses for literal checks.
  int q_data[$];
  int q_addr[$];
  int q_last[$];
  int q_maddr[$];

  always @(negedge clk) begin
    if (m_started && !rst) begin
      if (bus.out_valid && bus.out_ready) begin
        q_data.push_back(int'(bus.out_data));
        q_addr.push_back(int'(bus.out_addr));
        q_last.push_back(int'(bus.out_last));
      end
      if (bus.mem_ce) q_maddr.push_back(int'(bus.mem_addr));
    end
  end

  task automatic clear_queues();
    q_data.delete();
    q_addr.delete();
    q_last.delete();
    q_maddr.delete();
  endtask

  // Present a request until it is accepted; returns one tick into the FETCH cycle.
  task automatic send(input logic [3:0] addr, input logic [3:0] count);
    bit seen;
    seen = 0;
    @(posedge clk); #1;
    clear_queues();
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_count = count;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        seen = 1;
        break;
      end
    end
    check("req_accept_seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1;
        break;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic check_list(input string name, input int got[$], input int exp[$]);
    check({name, "_len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check(name, 32'(got[i]), 32'(exp[i]));
  endtask

  initial begin
    int exp_full[$];
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = 4'd0;
    bus.req_count = 4'd0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 4'(i);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_addr", 32'(bus.out_addr), 32'd0);
    check("rst_mem_ce", 32'(bus.mem_ce), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);

    // Basic burst 2..5.
    send(4'd2, 4'd3);
    wait_done(40);
    check("basic_sum", 32'(bus.sum), 32'd14);
    check_list("basic_data", q_data, '{2, 3, 4, 5});
    check_list("basic_last", q_last, '{0, 0, 0, 1});

    // Address wrap 14,15,0,1.
    send(4'd14, 4'd3);
    wait_done(40);
    check("wrap_sum", 32'(bus.sum), 32'd30);
    check_list("wrap_data", q_data, '{14, 15, 0, 1});
    check_list("wrap_addr", q_addr, '{14, 15, 0, 1});
    check_list("wrap_maddr", q_maddr, '{14, 15, 0, 1});

    // Backpressure on the second word.
    send(4'd4, 4'd2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_out_data", 32'(bus.out_data), 32'd5);
      check("bp_mem_addr", 32'(bus.mem_addr), 32'd6);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    wait_done(40);
    check("bp_sum", 32'(bus.sum), 32'd15);
    check_list("bp_data", q_data, '{4, 5, 6});

    // Single word.
    send(4'd9, 4'd0);
    wait_done(40);
    check("single_sum", 32'(bus.sum), 32'd9);
    check_list("single_data", q_data, '{9});
    check_list("single_last", q_last, '{1});
    check_list("single_maddr", q_maddr, '{9});

    // Full bank, with a competing request raised mid-burst.
    send(4'd0, 4'd15);
    repeat (3) @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 4'd7;
    bus.req_count = 4'd1;
    wait_done(60);
    check("full_sum", 32'(bus.sum), 32'd120);
    for (int i = 0; i < 16; i++) exp_full.push_back(i);
    check_list("full_data", q_data, exp_full);
    clear_queues();
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (bus.req_ready) begin
          seen = 1;
          break;
        end
      end
      check("pending_accept_seen", 32'(seen), 32'd1);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    wait_done(40);
    check("pending_sum", 32'(bus.sum), 32'd15);
    check_list("pending_data", q_data, '{7, 8});

    // Reset during the third beat.
    send(4'd3, 4'd5);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_req_ready_pre", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_mem_ce", 32'(bus.mem_ce), 32'd0);
    check("mid_rst_sum", 32'(bus.sum), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    check("mid_rst_out_data", 32'(bus.out_data), 32'd0);
    check("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_release_ready", 32'(bus.req_ready), 32'd1);

    // Recovery burst after the abandoned one.
    send(4'd1, 4'd1);
    wait_done(40);
    check("recover_sum", 32'(bus.sum), 32'd3);
    check_list("recover_data", q_data, '{1, 2});

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
